vote_tally: RTL
===============

# vote_tally

Sequential vote-capture and tally stage that sits directly downstream of the 16-to-4 priority encoder in the voting machine. It accepts one vote per officer-issued ballot, taking the encoder's `valid`/4-bit code pair as its input. It requires a candidate code to be held stable before accepting it. It then increments that candidate's counter and locks out further input until the key is released and a new ballot is issued. Counters are read back through a registered select port.

## Interface

**Parameters**
- `NUM_CAND`, default 16: number of candidate counters; equals 2^width of `enc_code`.
- `CNT_W`, default 16: width of each per-candidate counter and of `total_votes`.
- `HOLD_CYCLES`, default 4: consecutive stable cycles required to accept a code; legal range ≥ 1.

**Ports**
- `clk` — input, 1: single clock; all state changes on its rising edge.
- `rst` — input, 1: asynchronous, active-high reset.
- `ballot_en` — input, 1: officer pulse that arms one vote.
- `enc_valid` — input, 1: encoder valid (any key pressed).
- `enc_code` — input, 4: encoder output code.
- `rd_sel` — input, 4: candidate index to read.
- `rd_count` — output, CNT_W: registered count of candidate `rd_sel`.
- `total_votes` — output, CNT_W: sum of accepted votes.
- `ready` — output, 1: high in ARMED (voter may press).
- `vote_done` — output, 1: one-cycle pulse when a vote is committed.
- `voted_code` — output, 4: code of the last committed vote.
- `sat` — output, 1: sticky; set when any counter or `total_votes` saturates.

## Operation

- **IDLE**
  - `ballot_en` = 1 → ARMED.
  - `enc_valid` is ignored.
- **ARMED**
  - `enc_valid` = 1 → load `held_code` = `enc_code`, set `stable_cnt` = 1, go to DEBOUNCE.
  - If `HOLD_CYCLES` = 1, go straight to COMMIT.
- **DEBOUNCE**
  - `enc_valid` = 0 → ARMED.
  - `enc_valid` = 1 and `enc_code` ≠ `held_code` → reload `held_code`, set `stable_cnt` = 1.
  - Otherwise `stable_cnt` += 1. When it reaches `HOLD_CYCLES` → COMMIT.
- **COMMIT** (one cycle)
  - `count[held_code]` += 1 and `total_votes` += 1, each saturating at 2^CNT_W − 1.
  - Set `sat` if either was already at maximum.
  - `voted_code` ← `held_code`; `vote_done` pulses.
  - Next state RELEASE.
- **RELEASE**
  - `enc_valid` = 0 → IDLE.
  - Holding the key never produces a second vote.
- `ballot_en` outside IDLE is ignored; it is not queued.
- Saturated counters hold their value. `sat` clears only on reset.
- Codes follow the encoder's priority: the highest set bit wins, so key 15 → code 4'b1111.

## Timing

- **Reset values:** all counters, `total_votes`, `rd_count`, `voted_code` = 0; `ready`, `vote_done`, `sat` = 0; state IDLE.
- Reset asserted mid-operation (any state) clears everything, including tallies.
- **Latency:**
  - First sampled `enc_valid` edge E0 gives ARMED→DEBOUNCE.
  - COMMIT is entered after edge E0 + HOLD_CYCLES − 1.
  - Counter updates at the next edge; `vote_done` is high for the one cycle following that edge.
  - With default parameters: E0 + 4 edges to the counter update.
- `ready` is high exactly while in ARMED. It is low throughout DEBOUNCE, COMMIT and RELEASE.
- `rd_count` reflects `rd_sel` one cycle later. A read of the candidate being committed returns the new value one cycle after the commit edge.
- A code change on the final debounce cycle restarts the count; there is no commit.

## Configuration

- `VOTE_TALLY_CLEAR_EN`
  - **Defined:** adds input `clear_all` (1 bit). When sampled high in IDLE, all counters, `total_votes`, `voted_code` and `sat` are zeroed on that edge. `clear_all` is ignored in all other states.
  - **Undefined:** no `clear_all` port; tallies clear only on `rst`.

## Structure

- Package `vote_pkg` holds:
  - state enum (IDLE, ARMED, DEBOUNCE, COMMIT, RELEASE);
  - `CODE_W` = 4;
  - default `CNT_W`.
- Sub-module `vote_debounce` contains the `held_code`/`stable_cnt` logic. It outputs `stable` (1-cycle) and `code`. The top module holds the FSM, counter array and read register.

## Test plan

- **Basic vote:** reset, pulse `ballot_en`, hold `enc_code` = 4'b0101 with valid for 6 cycles → `vote_done` once, `count[5]` = 1, `total_votes` = 1, `voted_code` = 5.
- **Debounce:** code 3 for 2 cycles, then 7 for 4 cycles → only `count[7]` increments; `count[3]` = 0.
- **Hold lockout:** keep valid high for 20 cycles after commit, then pulse `ballot_en` → a single vote is counted; `ballot_en` during RELEASE is ignored.
- **No ballot:** `enc_valid` pulses while IDLE → no count change; `ready` = 0.
- **Saturation:** CNT_W = 2, four votes for code 15 → `count[15]` = 3, `sat` = 1 after the fourth.
- **Reset mid-DEBOUNCE:** assert `rst` at DEBOUNCE cycle 2 after earlier votes → all counts 0, state IDLE, no `vote_done`.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared types and constants for the vote capture / tally slice.
package vote_pkg;

  localparam int CODE_W    = 4;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DEBOUNCE,
    ST_COMMIT,
    ST_RELEASE
  } state_e;

endpackage

// File: rtl/vote_debounce.sv
// Holds the candidate code and counts consecutive stable cycles; `stable` marks
// the edge on which the code has been held for HOLD_CYCLES samples.
module vote_debounce
  import vote_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              active,
  input  logic              enc_valid,
  input  logic [CODE_W-1:0] enc_code,
  output logic              stable,
  output logic [CODE_W-1:0] code
);

  localparam int SW = $clog2(HOLD_CYCLES + 1);

  logic [CODE_W-1:0] held_code_q, held_code_d;
  logic [SW-1:0]     stable_cnt_q, stable_cnt_d;

  always_comb begin
    held_code_d  = held_code_q;
    stable_cnt_d = stable_cnt_q;
    stable       = 1'b0;
    if (start) begin
      held_code_d  = enc_code;
      stable_cnt_d = SW'(1);
      stable       = (HOLD_CYCLES == 1);
    end else if (active && enc_valid) begin
      if (enc_code != held_code_q) begin
        held_code_d  = enc_code;
        stable_cnt_d = SW'(1);
      end else begin
        stable_cnt_d = stable_cnt_q + SW'(1);
        stable       = (int'(stable_cnt_d) == HOLD_CYCLES);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_code_q  <= '0;
      stable_cnt_q <= '0;
    end else begin
      held_code_q  <= held_code_d;
      stable_cnt_q <= stable_cnt_d;
    end
  end

  assign code = held_code_q;

endmodule

// File: rtl/vote_tally.sv
// One-vote-per-ballot capture FSM, saturating per-candidate tallies and a
// registered read port. `VOTE_TALLY_CLEAR_EN adds a clear_all input honoured in IDLE.
module vote_tally
  import vote_pkg::*;
#(
  parameter int NUM_CAND    = 16,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ballot_en,
`ifdef VOTE_TALLY_CLEAR_EN
  input  logic              clear_all,
`endif
  input  logic              enc_valid,
  input  logic [CODE_W-1:0] enc_code,
  input  logic [CODE_W-1:0] rd_sel,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  total_votes,
  output logic              ready,
  output logic              vote_done,
  output logic [CODE_W-1:0] voted_code,
  output logic              sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CAND];
  logic [CNT_W-1:0]  cnt_d [NUM_CAND];
  logic [CNT_W-1:0]  total_q, total_d;
  logic [CNT_W-1:0]  rd_count_q, rd_count_d;
  logic [CODE_W-1:0] voted_q, voted_d;
  logic              vote_done_q, vote_done_d;
  logic              sat_q, sat_d;

  logic              clr_req;
  logic              deb_stable;
  logic [CODE_W-1:0] deb_code;

`ifdef VOTE_TALLY_CLEAR_EN
  assign clr_req = clear_all;
`else
  assign clr_req = 1'b0;
`endif

  vote_debounce #(.HOLD_CYCLES(HOLD_CYCLES)) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .start     (state_q == ST_ARMED && enc_valid),
    .active    (state_q == ST_DEBOUNCE),
    .enc_valid (enc_valid),
    .enc_code  (enc_code),
    .stable    (deb_stable),
    .code      (deb_code)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    total_d     = total_q;
    voted_d     = voted_q;
    sat_d       = sat_q;
    vote_done_d = 1'b0;
    rd_count_d  = cnt_q[rd_sel];
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          for (int unsigned i = 0; i < NUM_CAND; i++) cnt_d[i] = '0;
          total_d = '0;
          voted_d = '0;
          sat_d   = 1'b0;
        end
        if (ballot_en) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (enc_valid) state_d = deb_stable ? ST_COMMIT : ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (!enc_valid)     state_d = ST_ARMED;
        else if (deb_stable) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        // Saturate rather than wrap; either counter pinned at max sets the sticky flag.
        if (cnt_q[deb_code] == CNT_MAX) sat_d = 1'b1;
        else cnt_d[deb_code] = cnt_q[deb_code] + 1'b1;
        if (total_q == CNT_MAX) sat_d = 1'b1;
        else total_d = total_q + 1'b1;
        voted_d     = deb_code;
        vote_done_d = 1'b1;
        state_d     = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!enc_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      for (int unsigned i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
      total_q     <= '0;
      rd_count_q  <= '0;
      voted_q     <= '0;
      vote_done_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      total_q     <= total_d;
      rd_count_q  <= rd_count_d;
      voted_q     <= voted_d;
      vote_done_q <= vote_done_d;
      sat_q       <= sat_d;
    end
  end

  assign rd_count    = rd_count_q;
  assign total_votes = total_q;
  assign ready       = (state_q == ST_ARMED);
  assign vote_done   = vote_done_q;
  assign voted_code  = voted_q;
  assign sat         = sat_q;

endmodule
